// File: rtl/logic_op_arbiter_pkg.sv
// Shared opcode encodings and arbiter state type for the logic-op arbiter slice.
// Pure declarations: no latency or flow control of its own.
package logic_op_arbiter_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
    localparam logic [OP_W-1:0] OP_NAND = 3'd3;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd5;

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } arb_state_t;

endpackage

// File: rtl/logic_op_unit.sv
// Bitwise logic unit: applies one of six logic ops to a and b, flags codes 6/7.
// Purely combinational, zero latency; no backpressure.
module logic_op_unit
    import logic_op_arbiter_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [OP_W-1:0] op,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    output logic [W-1:0]    y,
    output logic            err
);

    always_comb begin
        y   = '0;
        err = 1'b0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin shares one logic_op_unit among NREQ requesters into a one-entry result slot.
// Latency: accept in cycle N -> rsp_valid in N+1; full throughput when rsp_ready stays high.
// Backpressure: rsp_ready low with slot full blocks all grants. Optional LOGIC_OP_ARB_STATS_EN adds grant counters.
module logic_op_arbiter
    import logic_op_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [OP_W*NREQ-1:0] req_op,
    input  logic [W*NREQ-1:0]    req_a,
    input  logic [W*NREQ-1:0]    req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [W-1:0]         rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic                 rsp_err
`ifdef LOGIC_OP_ARB_STATS_EN
    ,
    output logic [16*NREQ-1:0]   stat_grants
`endif
);

    localparam int LGW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t      state;
    logic [LGW-1:0]  last_grant;
    logic [LGW-1:0]  gnt_idx;
    logic            gnt_any;
    logic            can_accept;
    logic            grant;
    logic [OP_W-1:0] sel_op;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;
    logic [W-1:0]    unit_y;
    logic            unit_err;

    // Lowest valid index overall, then overridden by the lowest valid index above
    // last_grant: that is exactly the circular search starting at last_grant+1.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                gnt_any = 1'b1;
                gnt_idx = LGW'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (i > int'(last_grant))) begin
                gnt_idx = LGW'(i);
            end
        end

        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == LGW'(i)) begin
                sel_op = req_op[OP_W*i +: OP_W];
                sel_a  = req_a[W*i +: W];
                sel_b  = req_b[W*i +: W];
            end
        end
    end

    assign can_accept = (state == ST_IDLE) || rsp_ready;
    assign grant      = can_accept && gnt_any;
    assign rsp_valid  = (state == ST_HOLD);

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = grant && !rst && (gnt_idx == LGW'(i));
        end
    end

    logic_op_unit #(.W(W)) u_unit (
        .op  (sel_op),
        .a   (sel_a),
        .b   (sel_b),
        .y   (unit_y),
        .err (unit_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            rsp_data   <= '0;
            rsp_id     <= '0;
            rsp_err    <= 1'b0;
            last_grant <= LGW'(NREQ - 1);
        end else if (grant) begin
            state      <= ST_HOLD;
            rsp_data   <= unit_y;
            rsp_id     <= IDW'(gnt_idx);
            rsp_err    <= unit_err;
            last_grant <= gnt_idx;
        end else if ((state == ST_HOLD) && rsp_ready) begin
            state <= ST_IDLE;
        end
    end

`ifdef LOGIC_OP_ARB_STATS_EN
    for (genvar g = 0; g < NREQ; g++) begin : g_stat
        logic [15:0] cnt;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
            end else if (req_ready[g] && (cnt != 16'hFFFF)) begin
                cnt <= cnt + 16'd1;
            end
        end
        assign stat_grants[16*g +: 16] = cnt;
    end
`endif

endmodule
